// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch stage.
//   OPC_LOAD / OPC_STORE : opcodes routed to the load/store buffer
//   OPC_LSB / OPC_MSB    : opcode field position inside an instruction word
//   dsp_state_e          : dispatch sequencer states
//   is_mem_op()          : true when an opcode targets the LSB
package dispatch_ctrl_pkg;

    localparam int unsigned OPC_LSB = 0;
    localparam int unsigned OPC_MSB = 6;

    localparam logic [OPC_MSB:OPC_LSB] OPC_LOAD  = 7'b0000011;
    localparam logic [OPC_MSB:OPC_LSB] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        DSP_IDLE  = 2'b00,
        DSP_RUN   = 2'b01,
        DSP_STALL = 2'b10,
        DSP_FLUSH = 2'b11
    } dsp_state_e;

    function automatic logic is_mem_op(input logic [OPC_MSB:OPC_LSB] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/dispatch_ctrl_fifo.sv
// dispatch_fifo: DEPTH-entry instruction buffer for the dispatch stage.
//   clk        clock
//   rst        synchronous reset, active-high
//   clear      synchronous discard of all entries (pipeline flush)
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        retire the head entry
//   head_data  current head entry (meaningless when count==0)
//   count      number of valid entries, 0..DEPTH
module dispatch_fifo
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_data;
    end

    assign head_data = mem[head_ptr];

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: decode/rename sequencer. Buffers fetched instructions,
// presents the head to the decoder and allocates one uop per cycle into the
// ROB plus either the IQ or the LSB when both targets have room.
//   clk_in/rst_in        clock, synchronous active-high reset
//   rdy_in               global enable; low holds all state and blocks alloc
//   fetch_*              fetch handshake (fetch_ready back-pressures fetch)
//   dec_*                head instruction to the decoder
//   rob/iq/lsb_valid     target has a free entry
//   rob/iq/lsb_alloc     write the decoded uop this cycle
//   flush_in             mispredict flush, discards all buffered instructions
//   stall_cnt            saturating count of cycles spent in STALL
// Build option: DISPATCH_BYPASS_EN lets an instruction arriving at an empty
// buffer go straight to the decoder and allocate in the same cycle.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INS_W  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              fetch_valid,
    input  logic [INS_W-1:0]  fetch_ins,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    output logic [INS_W-1:0]  dec_ins,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              dec_valid,
    input  logic              rob_valid,
    input  logic              iq_valid,
    input  logic              lsb_valid,
    output logic              rob_alloc,
    output logic              iq_alloc,
    output logic              lsb_alloc,
    input  logic              flush_in,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = INS_W + ADDR_W;

    dsp_state_e       state;
    dsp_state_e       state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [ENT_W-1:0] head_data;
    logic             fifo_nonempty;
    logic             bypass;
    logic             is_mem;
    logic             go;
    logic             push;
    logic             pop;

    dispatch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .clear     (flush_in),
        .push      (push),
        .push_data ({fetch_ins, fetch_pc}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    always_comb begin
        fifo_nonempty = (count != '0);
        bypass        = 1'b0;
        dec_valid     = fifo_nonempty;
        dec_ins       = '0;
        dec_pc        = '0;
        if (fifo_nonempty) begin
            dec_ins = head_data[ENT_W-1:ADDR_W];
            dec_pc  = head_data[ADDR_W-1:0];
        end
`ifdef DISPATCH_BYPASS_EN
        else if (fetch_valid && (state != DSP_FLUSH)) begin
            bypass    = 1'b1;
            dec_valid = 1'b1;
            dec_ins   = fetch_ins;
            dec_pc    = fetch_pc;
        end
`endif

        is_mem = is_mem_op(dec_ins[OPC_MSB:OPC_LSB]);
        go     = rdy_in && dec_valid && rob_valid
                 && (is_mem ? lsb_valid : iq_valid) && !flush_in;

        rob_alloc = go;
        iq_alloc  = go && !is_mem;
        lsb_alloc = go && is_mem;

        // count[PTR_W] is set only when the buffer is full.
        fetch_ready = (state != DSP_FLUSH) && (!count[PTR_W] || go);

        // A bypassed instruction that allocates never enters the buffer.
        pop  = go && fifo_nonempty;
        push = rdy_in && fetch_valid && fetch_ready && !flush_in && !(bypass && go);

        count_nxt = count + CNT_W'(push) - CNT_W'(pop);

        state_nxt = state;
        if (flush_in) begin
            state_nxt = DSP_FLUSH;
        end else if (rdy_in) begin
            if (count_nxt == '0)
                state_nxt = DSP_IDLE;
            else if (dec_valid && !go)
                state_nxt = DSP_STALL;
            else
                state_nxt = DSP_RUN;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= DSP_IDLE;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (rdy_in && (state == DSP_STALL) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
